// File: rtl/disp_tiempo_7seg_pkg.sv
// Shared types and constants for the 4-digit 7-segment time display.
//   conv_state_t : converter FSM states
//   NUM_DIG      : number of display digits
//   MAX_VAL      : largest value the display can show (inputs above it clamp)
//   SEG_OFF      : all segments dark (active-low)
//   seg_decode() : BCD digit -> {g,f,e,d,c,b,a}, active-low
package disp_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} conv_state_t;

  localparam int NUM_DIG = 4;
  localparam int MAX_VAL = 9999;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/disp_tiempo_7seg_if.sv
// Display-side bundle between the timer stage and the 7-segment driver.
//   valor : binary millisecond count (master -> slave)
//   seg   : segments {g,f,e,d,c,b,a}, active-low
//   dp    : decimal point, active-low
//   an    : digit anodes, active-low one-hot, an[0] = units
//   busy  : conversion in progress
interface disp_tiempo_7seg_if #(parameter int BIN_W = 15);
  logic [BIN_W-1:0] valor;
  logic [6:0]       seg;
  logic             dp;
  logic [3:0]       an;
  logic             busy;

  modport master (output valor, input seg, dp, an, busy);
  modport slave  (input valor, output seg, dp, an, busy);
endinterface

// File: rtl/disp_tiempo_7seg_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per cycle.
//   clk, reset : clock, synchronous active-high reset
//   bin_in     : binary value, re-converted whenever it differs from the last one loaded
//   bcd_out    : four BCD digits {thousands, hundreds, tens, units}
//   busy       : high while LOAD/SHIFT/COMMIT
//
// state  | meaning
// IDLE   | waiting for bin_in to differ from last_conv
// LOAD   | capture and clamp input, clear scratch
// SHIFT  | BIN_W adjust-and-shift iterations
// COMMIT | publish scratch to bcd_out
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int BIN_W = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] bin_in,
  output logic [15:0]      bcd_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(BIN_W - 1);

  conv_state_t      state, next_state;
  logic [BIN_W-1:0] bin_sr, last_conv;
  logic [15:0]      scratch, scratch_adj;
  logic [CNT_W-1:0] iter;
  logic             load_en, shift_en, commit_en;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bin_in != last_conv) next_state = LOAD;
      LOAD:    next_state = SHIFT;
      SHIFT:   if (iter == ITER_LAST) next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load_en   = (state == LOAD);
    shift_en  = (state == SHIFT);
    commit_en = (state == COMMIT);
  end

  // Registered from next_state so busy is a flop yet lines up with the state.
  always_ff @(posedge clk) begin
    if (reset) busy <= 1'b0;
    else       busy <= (next_state != IDLE);
  end

  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_sr    <= '0;
      last_conv <= '0;
      scratch   <= '0;
      iter      <= '0;
      bcd_out   <= '0;
    end else begin
      if (load_en) begin
        // last_conv keeps the raw value so an out-of-range input does not retrigger forever.
        last_conv <= bin_in;
        bin_sr    <= (bin_in > BIN_W'(MAX_VAL)) ? BIN_W'(MAX_VAL) : bin_in;
        scratch   <= '0;
        iter      <= '0;
      end
      if (shift_en) begin
        {scratch, bin_sr} <= {scratch_adj, bin_sr} << 1;
        iter              <= iter + CNT_W'(1);
      end
      if (commit_en) bcd_out <= scratch;
    end
  end

endmodule

// File: rtl/disp_tiempo_7seg.sv
// 4-digit multiplexed 7-segment display for the pulse-duration timer.
//   clk, reset : 50 MHz clock, synchronous active-high reset
//   bus        : slave side of disp_tiempo_7seg_if (valor in; seg/dp/an/busy out)
// Parameters: BIN_W input width, SCAN_DIV clk cycles per digit slot,
// BLANK_LZ = 1 blanks leading zeros (units digit always shown).
module disp_tiempo_7seg
  import disp_pkg::*;
#(
  parameter int BIN_W    = 15,
  parameter int SCAN_DIV = 50_000,
  parameter int BLANK_LZ = 0
) (
  input logic              clk,
  input logic              reset,
  disp_tiempo_7seg_if.slave bus
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  logic [PRE_W-1:0] pre;
  logic [1:0]       idx;
  logic [15:0]      digits;
  logic [3:0]       cur_digit;
  logic             blank;
  logic [6:0]       seg_nxt;

  bin2bcd_seq #(.BIN_W(BIN_W)) u_conv (
    .clk     (clk),
    .reset   (reset),
    .bin_in  (bus.valor),
    .bcd_out (digits),
    .busy    (bus.busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
      idx <= idx + 2'd1;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    cur_digit = digits[{idx, 2'b00} +: 4];
    blank     = 1'b0;
    if (BLANK_LZ != 0) begin
      case (idx)
        2'd1:    blank = (digits[15:4] == 12'd0);
        2'd2:    blank = (digits[15:8] == 8'd0);
        2'd3:    blank = (digits[15:12] == 4'd0);
        default: blank = 1'b0;
      endcase
    end
    seg_nxt = blank ? SEG_OFF : seg_decode(cur_digit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.seg <= SEG_OFF;
      bus.an  <= 4'b1111;
    end else begin
      bus.seg <= seg_nxt;
      bus.an  <= ~(4'b0001 << idx);
    end
  end

  assign bus.dp = 1'b1;

endmodule

// File: tb/tb_disp_tiempo_7seg.sv
module tb_disp_tiempo_7seg;

  localparam int SD = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  disp_tiempo_7seg_if #(.BIN_W(15)) bus_a ();
  disp_tiempo_7seg_if #(.BIN_W(15)) bus_b ();

  disp_tiempo_7seg #(.BIN_W(15), .SCAN_DIV(SD), .BLANK_LZ(0)) dut (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  disp_tiempo_7seg #(.BIN_W(15), .SCAN_DIV(SD), .BLANK_LZ(1)) dut_lz (
    .clk(clk), .reset(reset), .bus(bus_b.slave));

  int n_pass  = 0;
  int n_total = 0;
  int cyc;

  // clock edges since reset release; the reference scan slot is derived from it
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  logic [6:0] seg_ref [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic int clampv(int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic int pow10(int k);
    int p = 1;
    repeat (k) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] exp_seg(int v, int k, bit lz);
    int c = clampv(v);
    if (lz && k >= 1 && c < pow10(k)) return 7'b1111111;
    return seg_ref[(c / pow10(k)) % 10];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Watches 16 consecutive output cycles and compares them with the reference scan.
  task automatic check_scan(string tag, bit which, int v);
    int k;
    logic [3:0] e_an;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      k    = ((cyc - 1) / SD) % 4;
      e_an = ~(4'b0001 << k);
      if (!which) begin
        chk({tag, "_an"},  32'(bus_a.an),  32'(e_an));
        chk({tag, "_seg"}, 32'(bus_a.seg), 32'(exp_seg(v, k, 1'b0)));
      end else begin
        chk({tag, "_an"},  32'(bus_b.an),  32'(e_an));
        chk({tag, "_seg"}, 32'(bus_b.seg), 32'(exp_seg(v, k, 1'b1)));
      end
    end
    chk({tag, "_dp"}, 32'(which ? bus_b.dp : bus_a.dp), 32'd1);
  endtask

  // Counts samples with busy high, starting at the next clock; bounded.
  task automatic conv(bit which, output int n);
    n = 0;
    @(negedge clk);
    while (((which ? bus_b.busy : bus_a.busy) === 1'b1) && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, v, prev;
    bus_a.valor = '0;
    bus_b.valor = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_an",   32'(bus_a.an),   32'hF);
      chk("rst_seg",  32'(bus_a.seg),  32'h7F);
      chk("rst_busy", 32'(bus_a.busy), 32'd0);
      chk("rst_an_b", 32'(bus_b.an),   32'hF);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("rel_an",   32'(bus_a.an),   32'b1110);
    chk("rel_seg",  32'(bus_a.seg),  32'b1000000);
    chk("rel_busy", 32'(bus_a.busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(bus_a.busy), 32'd0);
    end
    check_scan("zero", 1'b0, 0);

    bus_a.valor = 15'd1234;
    conv(1'b0, n);
    chk("busy_1234", 32'(n), 32'd17);
    check_scan("d1234", 1'b0, 1234);

    bus_a.valor = 15'd9999;
    conv(1'b0, n);
    chk("busy_9999", 32'(n), 32'd17);
    check_scan("d9999", 1'b0, 9999);

    bus_a.valor = 15'd20000;
    conv(1'b0, n);
    chk("busy_clamp", 32'(n), 32'd17);
    check_scan("clamp", 1'b0, 20000);

    bus_a.valor = 15'd100;
    repeat (6) @(negedge clk);
    chk("mid_busy", 32'(bus_a.busy), 32'd1);
    bus_a.valor = 15'd4321;
    n = 0;
    while (bus_a.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("first_commit", 32'(dut.u_conv.bcd_out), 32'h0100);
    @(negedge clk);
    chk("retrigger", 32'(bus_a.busy), 32'd1);
    conv(1'b0, n);
    check_scan("d4321", 1'b0, 4321);

    prev = 4321;
    for (int r = 0; r < 5; r++) begin
      v = $urandom_range(0, 20000);
      if (v == prev) v = v + 1;
      if (v == 5678) v = 5679;
      bus_a.valor = 15'(v);
      conv(1'b0, n);
      chk("busy_rand", 32'(n), 32'd17);
      check_scan("rand", 1'b0, v);
      prev = v;
    end

    bus_a.valor = 15'd5678;
    repeat (8) @(negedge clk);
    chk("pre_rst_busy", 32'(bus_a.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_busy", 32'(bus_a.busy), 32'd0);
    chk("mrst_an",   32'(bus_a.an),   32'hF);
    chk("mrst_seg",  32'(bus_a.seg),  32'h7F);
    chk("mrst_dig",  32'(dut.u_conv.bcd_out), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_an",   32'(bus_a.an),   32'b1110);
    chk("post_seg",  32'(bus_a.seg),  32'b1000000);
    chk("post_busy", 32'(bus_a.busy), 32'd1);
    conv(1'b0, n);
    chk("busy_5678", 32'(n), 32'd16);
    check_scan("d5678", 1'b0, 5678);

    bus_b.valor = 15'd7;
    conv(1'b1, n);
    chk("busy_lz7", 32'(n), 32'd17);
    check_scan("lz7", 1'b1, 7);

    bus_b.valor = 15'd305;
    conv(1'b1, n);
    chk("busy_lz305", 32'(n), 32'd17);
    check_scan("lz305", 1'b1, 305);

    bus_b.valor = 15'd0;
    conv(1'b1, n);
    chk("busy_lz0", 32'(n), 32'd17);
    check_scan("lz0", 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
